// File: rtl/ds1302_ctrl.sv
// ds1302_ctrl
//
// Sequencer that sits in front of the ds1302_io command port. After reset it
// clears the DS1302 write-protect bit. If the clock-halt bit is set, it
// restarts the oscillator. It then polls the seven BCD time registers at a
// fixed interval and publishes each burst as one coherent snapshot. Host
// time-set requests are serviced between read bursts.
//
// Ports
//   sysclk, rst          : clock, synchronous active-high reset
//   set_req, set_time    : host time-set request (level) and {year,week,month,date,hour,min,sec}
//   set_ack              : one-cycle pulse when the seven set writes have completed
//   sec..year            : last coherent BCD snapshot
//   time_valid           : one-cycle pulse on the cycle the snapshot outputs update
//   busy                 : low only while the sequencer idles between bursts
//   cmd_read/cmd_write   : registered command requests to ds1302_io
//   cmd_read_ack/cmd_write_ack : one-cycle completion pulses from ds1302_io
//   read_addr/write_addr : DS1302 command bytes
//   read_data            : read result, valid in the ack cycle
//   write_data           : write payload
module ds1302_ctrl #(
  parameter int POLL_DIV = 5_000_000
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic        set_req,
  input  logic [55:0] set_time,
  output logic        set_ack,
  output logic [7:0]  sec,
  output logic [7:0]  min,
  output logic [7:0]  hour,
  output logic [7:0]  date,
  output logic [7:0]  month,
  output logic [7:0]  week,
  output logic [7:0]  year,
  output logic        time_valid,
  output logic        busy,
  output logic        cmd_read,
  output logic        cmd_write,
  input  logic        cmd_read_ack,
  input  logic        cmd_write_ack,
  output logic [7:0]  read_addr,
  output logic [7:0]  write_addr,
  input  logic [7:0]  read_data,
  output logic [7:0]  write_data
);

  localparam logic [23:0] POLL_LAST = 24'(POLL_DIV - 1);

  // S_RESET is the reset value. It gives one cycle in S_INIT_WP before the
  // first command rises.
  typedef enum logic [3:0] {
    S_RESET,
    S_INIT_WP,
    S_INIT_CHRD,
    S_INIT_CHWR,
    S_RD,
    S_UPDATE,
    S_WAIT,
    S_SET,
    S_SET_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  idx_reg, idx_next;
  logic [23:0] poll_cnt_reg, poll_cnt_next;
  logic        cmd_read_reg, cmd_read_next;
  logic        cmd_write_reg, cmd_write_next;
  logic [7:0]  read_addr_reg, read_addr_next;
  logic [7:0]  write_addr_reg, write_addr_next;
  logic [7:0]  write_data_reg, write_data_next;
  logic [6:0]  ch_sec_reg, ch_sec_next;     // seconds read at init, halt bit dropped
  logic [55:0] set_time_reg, set_time_next;
  logic        time_valid_reg, set_ack_reg, busy_reg;
  logic [7:0]  set_field;
  logic        rd_ack, wr_ack, shadow_we;
  logic [55:0] snap_vec;

  // Only an ack for the command type that is actually outstanding counts.
  // The two ack lines may be tied together upstream.
  assign rd_ack    = cmd_read_reg  && cmd_read_ack;
  assign wr_ack    = cmd_write_reg && cmd_write_ack;
  assign shadow_we = (state_reg == S_RD) && rd_ack;

  // Payload for set write idx. The seconds byte always has its halt bit
  // cleared, so a set can never stop the oscillator.
  always_comb begin
    set_field = set_time_reg[{idx_reg, 3'b000} +: 8];
    if (idx_reg == 3'd0) set_field[7] = 1'b0;
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    poll_cnt_next   = '0;
    cmd_read_next   = cmd_read_reg;
    cmd_write_next  = cmd_write_reg;
    read_addr_next  = read_addr_reg;
    write_addr_next = write_addr_reg;
    write_data_next = write_data_reg;
    ch_sec_next     = ch_sec_reg;
    set_time_next   = set_time_reg;

    case (state_reg)
      S_RESET: state_next = S_INIT_WP;

      S_INIT_WP: begin
        if (!cmd_write_reg) begin
          cmd_write_next  = 1'b1;
          write_addr_next = 8'h8E;
          write_data_next = 8'h00;
        end else if (wr_ack) begin
          cmd_write_next = 1'b0;
          state_next     = S_INIT_CHRD;
        end
      end

      S_INIT_CHRD: begin
        if (!cmd_read_reg) begin
          cmd_read_next  = 1'b1;
          read_addr_next = 8'h81;
        end else if (rd_ack) begin
          cmd_read_next = 1'b0;
          ch_sec_next   = read_data[6:0];
          state_next    = read_data[7] ? S_INIT_CHWR : S_RD;
        end
      end

      S_INIT_CHWR: begin
        if (!cmd_write_reg) begin
          cmd_write_next  = 1'b1;
          write_addr_next = 8'h80;
          write_data_next = {1'b0, ch_sec_reg};
        end else if (wr_ack) begin
          cmd_write_next = 1'b0;
          state_next     = S_RD;
        end
      end

      S_RD: begin
        if (!cmd_read_reg) begin
          cmd_read_next  = 1'b1;
          read_addr_next = 8'h81 + {4'd0, idx_reg, 1'b0};
        end else if (rd_ack) begin
          cmd_read_next = 1'b0;
          if (idx_reg == 3'd6) begin
            idx_next   = 3'd0;
            state_next = S_UPDATE;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end

      S_UPDATE: state_next = S_WAIT;

      S_WAIT: begin
        // A pending set wins over poll expiry in the same cycle.
        if (set_req) begin
          set_time_next = set_time;
          state_next    = S_SET;
        end else if (poll_cnt_reg == POLL_LAST) begin
          state_next = S_RD;
        end else begin
          poll_cnt_next = poll_cnt_reg + 24'd1;
        end
      end

      S_SET: begin
        if (!cmd_write_reg) begin
          cmd_write_next  = 1'b1;
          write_addr_next = 8'h80 + {4'd0, idx_reg, 1'b0};
          write_data_next = set_field;
        end else if (wr_ack) begin
          cmd_write_next = 1'b0;
          if (idx_reg == 3'd6) begin
            idx_next   = 3'd0;
            state_next = S_SET_DONE;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end

      S_SET_DONE: state_next = S_RD;

      default: state_next = S_RESET;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_reg      <= S_RESET;
      idx_reg        <= '0;
      poll_cnt_reg   <= '0;
      cmd_read_reg   <= 1'b0;
      cmd_write_reg  <= 1'b0;
      read_addr_reg  <= '0;
      write_addr_reg <= '0;
      write_data_reg <= '0;
      ch_sec_reg     <= '0;
      set_time_reg   <= '0;
      time_valid_reg <= 1'b0;
      set_ack_reg    <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      poll_cnt_reg   <= poll_cnt_next;
      cmd_read_reg   <= cmd_read_next;
      cmd_write_reg  <= cmd_write_next;
      read_addr_reg  <= read_addr_next;
      write_addr_reg <= write_addr_next;
      write_data_reg <= write_data_next;
      ch_sec_reg     <= ch_sec_next;
      set_time_reg   <= set_time_next;
      // The pulses land together with the snapshot and refresh they announce.
      time_valid_reg <= (state_reg == S_UPDATE);
      set_ack_reg    <= (state_reg == S_SET_DONE);
      busy_reg       <= (state_next != S_WAIT);
    end
  end

  // Per-field shadow register, filled during a burst, and the published
  // snapshot register. The snapshot is copied in one cycle so the outputs
  // never show a half-updated time.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_field
      logic [7:0] shadow_reg;
      logic [7:0] snap_reg;
      always_ff @(posedge sysclk) begin
        if (rst) begin
          shadow_reg <= '0;
          snap_reg   <= '0;
        end else begin
          if (shadow_we && (idx_reg == 3'(gi))) shadow_reg <= read_data;
          if (state_reg == S_UPDATE) snap_reg <= shadow_reg;
        end
      end
      assign snap_vec[8*gi +: 8] = snap_reg;
    end
  endgenerate

  assign sec        = snap_vec[7:0];
  assign min        = snap_vec[15:8];
  assign hour       = snap_vec[23:16];
  assign date       = snap_vec[31:24];
  assign month      = snap_vec[39:32];
  assign week       = snap_vec[47:40];
  assign year       = snap_vec[55:48];
  assign time_valid = time_valid_reg;
  assign set_ack    = set_ack_reg;
  assign busy       = busy_reg;
  assign cmd_read   = cmd_read_reg;
  assign cmd_write  = cmd_write_reg;
  assign read_addr  = read_addr_reg;
  assign write_addr = write_addr_reg;
  assign write_data = write_data_reg;

endmodule

// File: tb/tb_ds1302_ctrl.sv
// Directed testbench for ds1302_ctrl with POLL_DIV = 100 and a behavioural
// DS1302 + ds1302_io model that acks each command after ack_lat cycles.
module tb_ds1302_ctrl;

  localparam int POLL = 100;

  logic        sysclk = 1'b0;
  logic        rst = 1'b1;
  logic        set_req = 1'b0;
  logic [55:0] set_time = '0;
  logic        set_ack;
  logic [7:0]  sec, min, hour, date, month, week, year;
  logic        time_valid, busy, cmd_read, cmd_write;
  logic        cmd_read_ack = 1'b0, cmd_write_ack = 1'b0;
  logic [7:0]  read_addr, write_addr, write_data;
  logic [7:0]  read_data = 8'h00;

  int tests_run = 0;
  int tests_failed = 0;
  int ack_lat = 2;
  int tv_count = 0;
  int ack_count = 0;
  int preset_mode = 0;            // 0 keep chip regs, 1 load defaults, 2 load sec only
  logic [7:0] preset_sec = 8'h00;
  logic [7:0] mem [8];

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;
  txn_t log_q[$];

  // monitor state
  logic       pcr = 1'b0, pcw = 1'b0;
  logic [7:0] pra = '0, pwa = '0, pwd = '0;
  int         mcnt = 0;

  always #5 sysclk = ~sysclk;

  ds1302_ctrl #(.POLL_DIV(POLL)) dut (
    .sysclk(sysclk), .rst(rst),
    .set_req(set_req), .set_time(set_time), .set_ack(set_ack),
    .sec(sec), .min(min), .hour(hour), .date(date), .month(month),
    .week(week), .year(year),
    .time_valid(time_valid), .busy(busy),
    .cmd_read(cmd_read), .cmd_write(cmd_write),
    .cmd_read_ack(cmd_read_ack), .cmd_write_ack(cmd_write_ack),
    .read_addr(read_addr), .write_addr(write_addr),
    .read_data(read_data), .write_data(write_data)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1000000, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // Wait helper: sel 0 time_valid, 1 set_ack, 2 busy low, 3 cmd_read, 4 cmd_write.
  // Returns the number of negedges waited, or -1 if the bound expired.
  task automatic wait_for(input int sel, input int bound, output int n);
    n = -1;
    for (int k = 1; k <= bound; k++) begin
      @(negedge sysclk);
      if ((sel == 0 && time_valid) || (sel == 1 && set_ack) || (sel == 2 && !busy) ||
          (sel == 3 && cmd_read) || (sel == 4 && cmd_write)) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n, base, tv0;
    logic [7:0] ea [9] = '{8'h8E, 8'h81, 8'h81, 8'h83, 8'h85, 8'h87, 8'h89, 8'h8B, 8'h8D};
    bit         ew [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    preset_mode = 1; preset_sec = 8'h12; ack_lat = 2;
    rst = 1'b1;
    repeat (3) @(negedge sysclk);
    tests_run++;
    if ({cmd_read, cmd_write, busy, time_valid, set_ack} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b, required 00000", {cmd_read, cmd_write, busy, time_valid, set_ack});
    end
    tests_run++;
    if ({year, week, month, date, hour, min, sec} !== 56'd0) begin
      tests_failed++;
      $display("FAIL reset_time: got %h, required 0", {year, week, month, date, hour, min, sec});
    end
    tests_run++;
    if ({read_addr, write_addr, write_data} !== 24'd0) begin
      tests_failed++;
      $display("FAIL reset_addr: got %h, required 0", {read_addr, write_addr, write_data});
    end
    base = log_q.size(); tv0 = tv_count;
    rst = 1'b0;
    @(negedge sysclk);
    tests_run++;
    if (cmd_write !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL first_cycle: cmd_write=%b busy=%b, required 0 1", cmd_write, busy);
    end
    @(negedge sysclk);
    tests_run++;
    if (cmd_write !== 1'b1 || write_addr !== 8'h8E || write_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL wp_write: cmd_write=%b addr=%h data=%h, required 1 8e 00", cmd_write, write_addr, write_data);
    end
    wait_for(0, 2000, n);
    tests_run++;
    if (n < 0) begin
      tests_failed++;
      $display("FAIL init_tv_timeout: time_valid not seen, required within 2000 cycles");
    end
    tests_run++;
    if (log_q.size() - base != 9) begin
      tests_failed++;
      $display("FAIL init_len: got %0d transactions, required 9", log_q.size() - base);
    end else begin
      for (int i = 0; i < 9; i++) begin
        tests_run++;
        if (log_q[base+i].wr !== ew[i] || log_q[base+i].addr !== ea[i]) begin
          tests_failed++;
          $display("FAIL init_txn%0d: got wr=%0b addr=%h, required wr=%0b addr=%h",
                   i, log_q[base+i].wr, log_q[base+i].addr, ew[i], ea[i]);
        end
      end
      tests_run++;
      if (log_q[base].data !== 8'h00) begin
        tests_failed++;
        $display("FAIL wp_data: got %h, required 00", log_q[base].data);
      end
    end
    tests_run++;
    if ({year, week, month, date, hour, min, sec} !== 56'h24_05_06_15_08_34_12) begin
      tests_failed++;
      $display("FAIL init_snapshot: got %h, required 24050615083412", {year, week, month, date, hour, min, sec});
    end
    tests_run++;
    if (tv_count - tv0 != 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL init_tv_once: pulses=%0d busy=%b, required 1 0", tv_count - tv0, busy);
    end
  endtask

  task automatic test_halt_init();
    int n, base;
    preset_mode = 2; preset_sec = 8'h95; ack_lat = 2;
    rst = 1'b1;
    repeat (2) @(negedge sysclk);
    base = log_q.size();
    rst = 1'b0;
    wait_for(0, 3000, n);
    tests_run++;
    if (n < 0) begin
      tests_failed++;
      $display("FAIL halt_tv_timeout: time_valid not seen, required within 3000 cycles");
    end
    tests_run++;
    if (log_q.size() - base != 10) begin
      tests_failed++;
      $display("FAIL halt_len: got %0d transactions, required 10", log_q.size() - base);
    end else begin
      tests_run++;
      if (log_q[base+2].wr !== 1'b1 || log_q[base+2].addr !== 8'h80 || log_q[base+2].data !== 8'h15) begin
        tests_failed++;
        $display("FAIL halt_restart: got wr=%0b addr=%h data=%h, required 1 80 15",
                 log_q[base+2].wr, log_q[base+2].addr, log_q[base+2].data);
      end
      tests_run++;
      if (log_q[base+3].wr !== 1'b0 || log_q[base+3].addr !== 8'h81) begin
        tests_failed++;
        $display("FAIL halt_burst_start: got wr=%0b addr=%h, required 0 81", log_q[base+3].wr, log_q[base+3].addr);
      end
    end
    tests_run++;
    if (sec !== 8'h15) begin
      tests_failed++;
      $display("FAIL halt_sec: got %h, required 15", sec);
    end
  endtask

  task automatic test_set();
    int n, base, ack0;
    logic [7:0] ed [7] = '{8'h58, 8'h59, 8'h23, 8'h31, 8'h12, 8'h03, 8'h24};
    ack_lat = 2;
    wait_for(2, 300, n);
    base = log_q.size(); ack0 = ack_count;
    set_time = 56'h24_03_12_31_23_59_58;
    set_req = 1'b1;
    wait_for(1, 500, n);
    set_req = 1'b0;
    tests_run++;
    if (n < 0) begin
      tests_failed++;
      $display("FAIL set_ack_timeout: set_ack not seen, required within 500 cycles");
    end
    wait_for(3, 2, n);
    tests_run++;
    if (n < 0) begin
      tests_failed++;
      $display("FAIL set_refresh: cmd_read low 2 cycles after set_ack, required immediate burst");
    end
    wait_for(0, 500, n);
    tests_run++;
    if (log_q.size() - base != 14) begin
      tests_failed++;
      $display("FAIL set_len: got %0d transactions, required 14", log_q.size() - base);
    end else begin
      for (int i = 0; i < 7; i++) begin
        tests_run++;
        if (log_q[base+i].wr !== 1'b1 || log_q[base+i].addr !== 8'(8'h80 + 2*i) || log_q[base+i].data !== ed[i]) begin
          tests_failed++;
          $display("FAIL set_wr%0d: got wr=%0b addr=%h data=%h, required 1 %h %h",
                   i, log_q[base+i].wr, log_q[base+i].addr, log_q[base+i].data, 8'(8'h80 + 2*i), ed[i]);
        end
      end
      tests_run++;
      if (log_q[base+7].wr !== 1'b0 || log_q[base+13].addr !== 8'h8D) begin
        tests_failed++;
        $display("FAIL set_refresh_burst: got wr=%0b last=%h, required 0 8d", log_q[base+7].wr, log_q[base+13].addr);
      end
    end
    tests_run++;
    if ({year, week, month, date, hour, min, sec} !== 56'h24_03_12_31_23_59_58 || ack_count - ack0 != 1) begin
      tests_failed++;
      $display("FAIL set_snapshot: got %h acks=%0d, required 24031231235958 acks=1",
               {year, week, month, date, hour, min, sec}, ack_count - ack0);
    end
  endtask

  task automatic test_poll();
    int n;
    ack_lat = 300;
    for (int r = 0; r < 2; r++) begin
      wait_for(0, 3000, n);
      tests_run++;
      if (n < 0) begin
        tests_failed++;
        $display("FAIL poll_tv_timeout%0d: time_valid not seen, required within 3000 cycles", r);
      end
      wait_for(3, 200, n);
      tests_run++;
      if (n != POLL + 1) begin
        tests_failed++;
        $display("FAIL poll_period%0d: cmd_read rose after %0d cycles, required %0d", r, n, POLL + 1);
      end
    end
  endtask

  task automatic test_midburst_set();
    int n, base, tv0;
    logic [7:0] ed [7] = '{8'h45, 8'h30, 8'h12, 8'h15, 8'h01, 8'h07, 8'h99};
    ack_lat = 20;
    wait_for(0, 3000, n);
    wait_for(3, 200, n);
    tests_run++;
    if (n < 0) begin
      tests_failed++;
      $display("FAIL mid_start: cmd_read not seen, required within 200 cycles");
    end
    base = log_q.size(); tv0 = tv_count;
    set_time = 56'h99_07_01_15_12_30_C5;
    set_req = 1'b1;
    wait_for(1, 1000, n);
    set_req = 1'b0;
    tests_run++;
    if (n < 0 || tv_count - tv0 != 1) begin
      tests_failed++;
      $display("FAIL mid_order: set_ack wait=%0d tv pulses=%0d, required ack seen and 1 pulse", n, tv_count - tv0);
    end
    tests_run++;
    if (log_q.size() - base != 14) begin
      tests_failed++;
      $display("FAIL mid_len: got %0d transactions, required 14", log_q.size() - base);
    end else begin
      for (int i = 0; i < 7; i++) begin
        tests_run++;
        if (log_q[base+i].wr !== 1'b0 || log_q[base+i].addr !== 8'(8'h81 + 2*i)) begin
          tests_failed++;
          $display("FAIL mid_rd%0d: got wr=%0b addr=%h, required 0 %h", i, log_q[base+i].wr, log_q[base+i].addr, 8'(8'h81 + 2*i));
        end
        tests_run++;
        if (log_q[base+7+i].wr !== 1'b1 || log_q[base+7+i].data !== ed[i]) begin
          tests_failed++;
          $display("FAIL mid_wr%0d: got wr=%0b data=%h, required 1 %h", i, log_q[base+7+i].wr, log_q[base+7+i].data, ed[i]);
        end
      end
    end
    wait_for(0, 500, n);
    tests_run++;
    if ({year, week, month, date, hour, min, sec} !== 56'h99_07_01_15_12_30_45) begin
      tests_failed++;
      $display("FAIL mid_snapshot: got %h, required 99070115123045", {year, week, month, date, hour, min, sec});
    end
  endtask

  task automatic test_reset_mid_set();
    int n, base;
    bit found = 1'b0;
    ack_lat = 20; preset_mode = 0;
    wait_for(2, 10, n);
    set_time = 56'h00_00_00_00_00_08_07;
    set_req = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge sysclk);
      if (cmd_write && write_addr == 8'h84) begin
        found = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL rstset_reach: write to 84 not seen, required within 500 cycles");
    end
    rst = 1'b1; set_req = 1'b0;
    @(negedge sysclk);
    tests_run++;
    if ({cmd_read, cmd_write, busy, time_valid, set_ack} !== 5'b0 || {year, week, month, date, hour, min, sec} !== 56'd0) begin
      tests_failed++;
      $display("FAIL rstset_clear: ctrl=%b time=%h, required all 0",
               {cmd_read, cmd_write, busy, time_valid, set_ack}, {year, week, month, date, hour, min, sec});
    end
    base = log_q.size();
    rst = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk);
    tests_run++;
    if (cmd_write !== 1'b1 || write_addr !== 8'h8E) begin
      tests_failed++;
      $display("FAIL rstset_reinit: cmd_write=%b addr=%h, required 1 8e", cmd_write, write_addr);
    end
    wait_for(0, 3000, n);
    tests_run++;
    if (log_q.size() - base != 9 || log_q[base].addr !== 8'h8E) begin
      tests_failed++;
      $display("FAIL rstset_seq: got %0d transactions, required 9 starting with 8e", log_q.size() - base);
    end
    tests_run++;
    if ({year, week, month, date, hour, min, sec} !== 56'h99_07_01_15_12_08_07) begin
      tests_failed++;
      $display("FAIL rstset_snapshot: got %h, required 99070115120807", {year, week, month, date, hour, min, sec});
    end
  endtask

  initial begin
    fork
      // DS1302 + ds1302_io model: acks on the negedge, ack_lat cycles after a command is seen.
      begin
        forever begin
          @(negedge sysclk);
          if (rst) begin
            cmd_read_ack = 1'b0; cmd_write_ack = 1'b0; mcnt = 0;
            if (preset_mode == 1) begin
              mem[0] = preset_sec; mem[1] = 8'h34; mem[2] = 8'h08; mem[3] = 8'h15;
              mem[4] = 8'h06; mem[5] = 8'h05; mem[6] = 8'h24; mem[7] = 8'h80;
            end else if (preset_mode == 2) begin
              mem[0] = preset_sec;
            end
          end else if (cmd_read_ack || cmd_write_ack) begin
            cmd_read_ack = 1'b0; cmd_write_ack = 1'b0; mcnt = 0;
          end else if (cmd_read || cmd_write) begin
            if (mcnt >= ack_lat) begin
              txn_t t;
              mcnt = 0;
              if (cmd_read) begin
                read_data = mem[read_addr[3:1]];
                cmd_read_ack = 1'b1;
                t.wr = 1'b0; t.addr = read_addr; t.data = read_data;
              end else begin
                mem[write_addr[3:1]] = write_data;
                cmd_write_ack = 1'b1;
                t.wr = 1'b1; t.addr = write_addr; t.data = write_data;
              end
              log_q.push_back(t);
              $display("[TB] %s addr=0x%02h data=0x%02h", t.wr ? "WR" : "RD", t.addr, t.data);
            end else begin
              mcnt++;
            end
          end
        end
      end
      // Protocol monitor, sampling just after each rising edge.
      begin
        forever begin
          @(posedge sysclk);
          #1;
          if (time_valid) tv_count++;
          if (set_ack) ack_count++;
          if (!rst && (cmd_read || cmd_write || cmd_read_ack || cmd_write_ack)) begin
            tests_run++;
            if (cmd_read && cmd_write) begin
              tests_failed++;
              $display("FAIL cmd_exclusive: read=%b write=%b, required not both 1", cmd_read, cmd_write);
            end
            tests_run++;
            if ((cmd_read_ack && cmd_read) || (cmd_write_ack && cmd_write)) begin
              tests_failed++;
              $display("FAIL cmd_drop: cmd still high after its ack, required 0");
            end
            tests_run++;
            if (cmd_read && pcr && read_addr !== pra) begin
              tests_failed++;
              $display("FAIL rd_stable: addr %h, required %h", read_addr, pra);
            end
            tests_run++;
            if (cmd_write && pcw && {write_addr, write_data} !== {pwa, pwd}) begin
              tests_failed++;
              $display("FAIL wr_stable: got %h, required %h", {write_addr, write_data}, {pwa, pwd});
            end
          end
          pcr = cmd_read && !rst; pcw = cmd_write && !rst;
          pra = read_addr; pwa = write_addr; pwd = write_data;
        end
      end
    join_none

    test_reset();
    test_halt_init();
    test_set();
    test_poll();
    test_midburst_set();
    test_reset_mid_set();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
